ram_parametrizada: RTL and testbench

RAM_PARAMETRIZADA -- requirements
Module: ram_parametrizada

---
 rtl/ram_parametrizada_if.sv | 29 ++
 rtl/ram_parametrizada.sv | 118 +++++++++++
 tb/tb_ram_parametrizada.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ram_parametrizada_if.sv
// Bus bundle for ram_parametrizada: access requests in, registered read data and status out.
// The master modport drives requests; the slave modport is the RAM side.
interface ram_parametrizada_if #(
    parameter int LARGURA_DADOS = 16,
    parameter int LARGURA_END   = 14
);
    logic [LARGURA_DADOS-1:0] entrada_dados;
    logic [LARGURA_END-1:0]   endereco_mem;
    logic                     controle_escrita;
    logic                     pedido_leitura;
    logic                     pedido_limpeza;
    logic                     injeta_erro;
    logic [LARGURA_DADOS-1:0] saida_dados;
    logic                     saida_valida;
    logic                     ocupada;
    logic                     erro_paridade;

    modport master (
        output entrada_dados, endereco_mem, controle_escrita,
        output pedido_leitura, pedido_limpeza, injeta_erro,
        input  saida_dados, saida_valida, ocupada, erro_paridade
    );

    modport slave (
        input  entrada_dados, endereco_mem, controle_escrita,
        input  pedido_leitura, pedido_limpeza, injeta_erro,
        output saida_dados, saida_valida, ocupada, erro_paridade
    );
endinterface

// File: rtl/ram_parametrizada.sv
// Single-port RAM that zeroes itself after reset or on request; optional parity via RAM_PARAMETRIZADA_PARIDADE_EN.
// Latency: read data and saida_valida one edge after pedido_leitura; write-first on same-cycle read+write.
// Backpressure: none; while ocupada=1 (clear sweep) every request is silently dropped.
module ram_parametrizada #(
    parameter int LARGURA_DADOS = 16,
    parameter int LARGURA_END   = 14
) (
    input  logic             clock_sistema,
    input  logic             reset_sistema,
    ram_parametrizada_if.slave bus
);
    localparam int PROFUNDIDADE = 2 ** LARGURA_END;
`ifdef RAM_PARAMETRIZADA_PARIDADE_EN
    localparam int LARGURA_PAL = LARGURA_DADOS + 1;
`else
    localparam int LARGURA_PAL = LARGURA_DADOS;
`endif

    typedef enum logic {
        LIMPANDO = 1'b0,
        PRONTA   = 1'b1
    } estado_t;

    estado_t                  estado_q, estado_d;
    logic [LARGURA_END-1:0]   ptr_limpeza_q, ptr_limpeza_d;
    logic [LARGURA_DADOS-1:0] saida_dados_q, saida_dados_d;
    logic                     saida_valida_q, saida_valida_d;
    logic                     erro_paridade_q, erro_paridade_d;

    logic [LARGURA_PAL-1:0]   mem [PROFUNDIDADE];

    logic                     esc_en;
    logic [LARGURA_END-1:0]   esc_end;
    logic [LARGURA_PAL-1:0]   esc_pal;
    logic [LARGURA_PAL-1:0]   pal_usuario;
    logic [LARGURA_PAL-1:0]   pal_lida;
    logic                     erro_lido;

`ifdef RAM_PARAMETRIZADA_PARIDADE_EN
    assign pal_usuario = {bus.injeta_erro ^ (^bus.entrada_dados), bus.entrada_dados};
    assign erro_lido   = ^pal_lida;
`else
    logic injeta_unused;
    assign injeta_unused = bus.injeta_erro;
    assign pal_usuario   = bus.entrada_dados;
    assign erro_lido     = 1'b0;
`endif

    // Read and write share one address, so a concurrent write always forwards.
    assign pal_lida = bus.controle_escrita ? pal_usuario : mem[bus.endereco_mem];

    always_comb begin
        estado_d        = estado_q;
        ptr_limpeza_d   = ptr_limpeza_q;
        saida_dados_d   = saida_dados_q;
        saida_valida_d  = 1'b0;
        erro_paridade_d = 1'b0;
        esc_en          = 1'b0;
        esc_end         = bus.endereco_mem;
        esc_pal         = pal_usuario;
        case (estado_q)
            LIMPANDO: begin
                esc_en        = 1'b1;
                esc_end       = ptr_limpeza_q;
                esc_pal       = '0;
                ptr_limpeza_d = ptr_limpeza_q + 1'b1;
                if (&ptr_limpeza_q) begin
                    estado_d = PRONTA;
                end
            end
            PRONTA: begin
                if (bus.pedido_limpeza) begin
                    estado_d      = LIMPANDO;
                    ptr_limpeza_d = '0;
                end else begin
                    esc_en = bus.controle_escrita;
                    if (bus.pedido_leitura) begin
                        saida_dados_d   = pal_lida[LARGURA_DADOS-1:0];
                        saida_valida_d  = 1'b1;
                        erro_paridade_d = erro_lido;
                    end
                end
            end
            default: begin
                estado_d      = LIMPANDO;
                ptr_limpeza_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock_sistema or posedge reset_sistema) begin
        if (reset_sistema) begin
            estado_q        <= LIMPANDO;
            ptr_limpeza_q   <= '0;
            saida_dados_q   <= '0;
            saida_valida_q  <= 1'b0;
            erro_paridade_q <= 1'b0;
        end else begin
            estado_q        <= estado_d;
            ptr_limpeza_q   <= ptr_limpeza_d;
            saida_dados_q   <= saida_dados_d;
            saida_valida_q  <= saida_valida_d;
            erro_paridade_q <= erro_paridade_d;
        end
    end

    // Array has no reset; its contents are defined by the sweep that follows reset.
    always_ff @(posedge clock_sistema) begin
        if (esc_en) begin
            mem[esc_end] <= esc_pal;
        end
    end

    assign bus.saida_dados   = saida_dados_q;
    assign bus.saida_valida  = saida_valida_q;
    assign bus.erro_paridade = erro_paridade_q;
    assign bus.ocupada       = (estado_q == LIMPANDO);
endmodule

// File: tb/tb_ram_parametrizada.sv
// Directed and randomized bench for ram_parametrizada (16-bit words, 16 entries).
module tb_ram_parametrizada;
    logic clk;
    logic rst;

    ram_parametrizada_if #(.LARGURA_DADOS(16), .LARGURA_END(4)) bus ();

    ram_parametrizada #(.LARGURA_DADOS(16), .LARGURA_END(4)) dut (
        .clock_sistema (clk),
        .reset_sistema (rst),
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] ref_mem [16];
    int          ref_busy;
    logic [15:0] ref_dout;
    logic        ref_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.controle_escrita = 1'b0;
        bus.pedido_leitura   = 1'b0;
        bus.pedido_limpeza   = 1'b0;
        bus.injeta_erro      = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        do begin
            tick();
            n++;
            chk("valid_in_sweep", {31'd0, bus.saida_valida}, 32'd0);
        end while (bus.ocupada && n < 40);
    endtask

    // Reference: a sweep refuses 16 cycles of requests and leaves the whole array zero.
    task automatic passo(input logic wr, input logic rd, input logic limp,
                         input logic [3:0] a, input logic [15:0] d);
        bus.controle_escrita = wr;
        bus.pedido_leitura   = rd;
        bus.pedido_limpeza   = limp;
        bus.endereco_mem     = a;
        bus.entrada_dados    = d;
        if (ref_busy > 0) begin
            ref_busy--;
            ref_valid = 1'b0;
        end else if (limp) begin
            for (int i = 0; i < 16; i++) ref_mem[i] = 16'h0000;
            ref_busy  = 16;
            ref_valid = 1'b0;
        end else begin
            ref_valid = rd;
            if (wr) ref_mem[a] = d;
            if (rd) ref_dout = ref_mem[a];
        end
        tick();
        chk("rnd_ocupada", {31'd0, bus.ocupada}, {31'd0, ref_busy > 0});
        chk("rnd_valida", {31'd0, bus.saida_valida}, {31'd0, ref_valid});
        chk("rnd_dados", {16'd0, bus.saida_dados}, {16'd0, ref_dout});
        if (ref_valid) chk("rnd_erro", {31'd0, bus.erro_paridade}, 32'd0);
    endtask

    initial begin
        int n;
        idle();
        bus.endereco_mem  = 4'd0;
        bus.entrada_dados = 16'h0000;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_ocupada", {31'd0, bus.ocupada}, 32'd1);
        chk("rst_valida", {31'd0, bus.saida_valida}, 32'd0);
        chk("rst_dados", {16'd0, bus.saida_dados}, 32'd0);
        chk("rst_erro", {31'd0, bus.erro_paridade}, 32'd0);

        // Requests during the initial sweep must be dropped.
        rst = 1'b0;
        bus.controle_escrita = 1'b1;
        bus.pedido_leitura   = 1'b1;
        bus.endereco_mem     = 4'd0;
        bus.entrada_dados    = 16'hFFFF;
        count_busy(n);
        idle();
        chk("sweep_len", n, 32'd16);

        for (int a = 0; a < 16; a++) begin
            bus.endereco_mem   = 4'(a);
            bus.pedido_leitura = 1'b1;
            tick();
            chk("clr_valida", {31'd0, bus.saida_valida}, 32'd1);
            chk("clr_dados", {16'd0, bus.saida_dados}, 32'd0);
        end
        idle();

        bus.controle_escrita = 1'b1; bus.endereco_mem = 4'd0;  bus.entrada_dados = 16'hAAAA; tick();
        chk("wr_no_valid", {31'd0, bus.saida_valida}, 32'd0);
        bus.endereco_mem = 4'd15; bus.entrada_dados = 16'h5A5A; tick();
        idle();
        bus.pedido_leitura = 1'b1; bus.endereco_mem = 4'd0; tick();
        chk("rd0_valida", {31'd0, bus.saida_valida}, 32'd1);
        chk("rd0_dados", {16'd0, bus.saida_dados}, 32'h0000AAAA);
        bus.endereco_mem = 4'd15; tick();
        chk("rd15_dados", {16'd0, bus.saida_dados}, 32'h00005A5A);
        idle(); tick();
        chk("hold_valida", {31'd0, bus.saida_valida}, 32'd0);
        chk("hold_dados", {16'd0, bus.saida_dados}, 32'h00005A5A);

        bus.controle_escrita = 1'b1; bus.pedido_leitura = 1'b1;
        bus.endereco_mem = 4'd3; bus.entrada_dados = 16'h1234; tick();
        idle();
        chk("wf_valida", {31'd0, bus.saida_valida}, 32'd1);
        chk("wf_dados", {16'd0, bus.saida_dados}, 32'h00001234);
        bus.pedido_leitura = 1'b1; tick(); idle();
        chk("wf_stored", {16'd0, bus.saida_dados}, 32'h00001234);

        // Clear wins over a simultaneous write.
        bus.pedido_limpeza = 1'b1; bus.controle_escrita = 1'b1;
        bus.endereco_mem = 4'd2; bus.entrada_dados = 16'hBEEF; tick();
        idle();
        chk("limp_ocupada0", {31'd0, bus.ocupada}, 32'd1);
        chk("limp_valida", {31'd0, bus.saida_valida}, 32'd0);
        for (int i = 0; i < 15; i++) tick();
        chk("limp_ocupada15", {31'd0, bus.ocupada}, 32'd1);
        tick();
        chk("limp_done", {31'd0, bus.ocupada}, 32'd0);
        bus.pedido_leitura = 1'b1; bus.endereco_mem = 4'd2; tick(); idle();
        chk("limp_rd2", {16'd0, bus.saida_dados}, 32'd0);
        bus.pedido_leitura = 1'b1; bus.endereco_mem = 4'd3; tick(); idle();
        chk("limp_rd3", {16'd0, bus.saida_dados}, 32'd0);

        for (int i = 0; i < 16; i++) ref_mem[i] = 16'h0000;
        ref_busy  = 0;
        ref_dout  = 16'h0000;
        ref_valid = 1'b0;
        for (int s = 0; s < 300; s++) begin
            passo(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 39) == 0), 4'($urandom_range(0, 15)),
                  16'($urandom));
        end
        idle();

        n = 0;
        while (bus.ocupada && n < 40) begin tick(); n++; end
        chk("pre_rst_idle", {31'd0, bus.ocupada}, 32'd0);
        bus.controle_escrita = 1'b1; bus.endereco_mem = 4'd9; bus.entrada_dados = 16'hC3C3; tick();
        idle();
        bus.pedido_leitura = 1'b1; tick(); idle();
        chk("pre_rst_dados", {16'd0, bus.saida_dados}, 32'h0000C3C3);
        bus.pedido_limpeza = 1'b1; tick(); idle();
        for (int i = 0; i < 7; i++) tick();
        chk("mid_ocupada", {31'd0, bus.ocupada}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_dados", {16'd0, bus.saida_dados}, 32'd0);
        chk("async_ocupada", {31'd0, bus.ocupada}, 32'd1);
        tick();
        rst = 1'b0;
        count_busy(n);
        chk("rst_sweep_len", n, 32'd16);
        bus.pedido_leitura = 1'b1; bus.endereco_mem = 4'd9; tick(); idle();
        chk("rst_rd9_valida", {31'd0, bus.saida_valida}, 32'd1);
        chk("rst_rd9_dados", {16'd0, bus.saida_dados}, 32'd0);

`ifdef RAM_PARAMETRIZADA_PARIDADE_EN
        bus.controle_escrita = 1'b1; bus.injeta_erro = 1'b1;
        bus.endereco_mem = 4'd5; bus.entrada_dados = 16'h0001; tick(); idle();
        bus.pedido_leitura = 1'b1; tick(); idle();
        chk("par_bad_valida", {31'd0, bus.saida_valida}, 32'd1);
        chk("par_bad_dados", {16'd0, bus.saida_dados}, 32'h00000001);
        chk("par_bad_erro", {31'd0, bus.erro_paridade}, 32'd1);
        bus.controle_escrita = 1'b1; tick(); idle();
        bus.pedido_leitura = 1'b1; tick(); idle();
        chk("par_ok_erro", {31'd0, bus.erro_paridade}, 32'd0);
`else
        bus.controle_escrita = 1'b1; bus.injeta_erro = 1'b1;
        bus.endereco_mem = 4'd5; bus.entrada_dados = 16'h0001; tick(); idle();
        bus.pedido_leitura = 1'b1; tick(); idle();
        chk("nopar_dados", {16'd0, bus.saida_dados}, 32'h00000001);
        chk("nopar_erro", {31'd0, bus.erro_paridade}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
